// File: rtl/sync_tx_pkg.sv
// Shared definitions for the sync_tx line transmitter: line codes, FSM states,
// SYNC pattern and stuffing limit.
package sync_tx_pkg;

    localparam int unsigned LINE_W       = 2;
    localparam int unsigned SYNC_LEN     = 8;
    localparam int unsigned SYNC_IDX_W   = 3;
    localparam int unsigned SYNC_ERR_IDX = 5;
    localparam int unsigned STUFF_LIMIT  = 6;
    localparam int unsigned ONES_W       = 3;

    // Line codes as {k, j}; 2'b11 is never driven.
    localparam logic [LINE_W-1:0] LS_SE0 = 2'b00;
    localparam logic [LINE_W-1:0] LS_J   = 2'b01;
    localparam logic [LINE_W-1:0] LS_K   = 2'b10;

    // Element 0 goes out first: K J K J K J K K.
    localparam logic [SYNC_LEN-1:0][LINE_W-1:0] SYNC_PATTERN =
        '{LS_K, LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SYNC = 2'b01,
        ST_DATA = 2'b10,
        ST_EOP  = 2'b11
    } state_t;

    // Registered line-side output bundle.
    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic              en;
        logic              busy;
        logic              done;
    } tx_out_t;

    // SYNC symbol for a given index; inj forces the sixth symbol to K.
    function automatic logic [LINE_W-1:0] sync_symbol(input logic [SYNC_IDX_W-1:0] idx,
                                                      input logic                  inj);
        logic [LINE_W-1:0] sym;
        sym = SYNC_PATTERN[idx];
        if (inj && (idx == SYNC_IDX_W'(SYNC_ERR_IDX))) begin
            sym = LS_K;
        end
        return sym;
    endfunction

endpackage

// File: rtl/sync_tx_nrzi.sv
// NRZI line-level tracker with the consecutive-ones counter used for bit stuffing.
module sync_tx_nrzi
    import sync_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic data_bit,
    input  logic valid,
    input  logic load_k,
    output logic level_nxt_k_c,
    output logic stuff_req_c
);

    logic              level_k_q;
    logic [ONES_W-1:0] ones_q;

    // A zero toggles the line, a one holds it.
    assign level_nxt_k_c = (valid && !data_bit) ? ~level_k_q : level_k_q;
    assign stuff_req_c   = (ones_q == ONES_W'(STUFF_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_k_q <= 1'b0;
            ones_q    <= '0;
        end else if (load_k) begin
            level_k_q <= 1'b1;
            ones_q    <= '0;
        end else if (valid) begin
            level_k_q <= level_nxt_k_c;
            if (!data_bit) begin
                ones_q <= '0;
            end else if (ones_q < ONES_W'(STUFF_LIMIT)) begin
                ones_q <= ones_q + ONES_W'(1);
            end
        end
    end

endmodule

// File: rtl/sync_tx.sv
// Line-side K/J transmitter: SYNC, NRZI bit-stuffed payload, then EOP.
// Optional SYNC corruption hook enabled by defining SYNC_TX_ERRINJ_EN.
module sync_tx
    import sync_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned EOP_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
`ifdef SYNC_TX_ERRINJ_EN
    input  logic              err_inj,
`endif
    output logic              tx_k,
    output logic              tx_j,
    output logic              tx_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned EOP_CNT_W = $clog2(EOP_LEN + 1);

    state_t                 state_q,   state_d;
    logic [SYNC_IDX_W-1:0]  sync_idx_q, sync_idx_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [EOP_CNT_W-1:0]   eop_cnt_q, eop_cnt_d;
    logic [DATA_W-1:0]      shift_q,   shift_d;
    logic                   inj_q,     inj_d;
    tx_out_t                out_q,     out_d;

    logic                   inj_capture_c;
    logic                   nrzi_bit_c;
    logic                   nrzi_valid_c;
    logic                   nrzi_load_k_c;
    logic                   level_nxt_k_c;
    logic                   stuff_req_c;

`ifdef SYNC_TX_ERRINJ_EN
    assign inj_capture_c = err_inj;
`else
    assign inj_capture_c = 1'b0;
`endif

    assign tx_k  = out_q.line[1];
    assign tx_j  = out_q.line[0];
    assign tx_en = out_q.en;
    assign busy  = out_q.busy;
    assign done  = out_q.done;

    sync_tx_nrzi u_nrzi (
        .clk           (clk),
        .rst           (rst),
        .data_bit      (nrzi_bit_c),
        .valid         (nrzi_valid_c),
        .load_k        (nrzi_load_k_c),
        .level_nxt_k_c (level_nxt_k_c),
        .stuff_req_c   (stuff_req_c)
    );

    // State, counters, payload and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync_idx_q <= '0;
            bit_cnt_q  <= '0;
            eop_cnt_q  <= '0;
            shift_q    <= '0;
            inj_q      <= 1'b0;
            out_q      <= '{line: LS_J, en: 1'b0, busy: 1'b0, done: 1'b0};
        end else begin
            state_q    <= state_d;
            sync_idx_q <= sync_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            eop_cnt_q  <= eop_cnt_d;
            shift_q    <= shift_d;
            inj_q      <= inj_d;
            out_q      <= out_d;
        end
    end

    // Next-state and next-output: state_q names the symbol produced on the coming edge.
    always_comb begin
        state_d       = state_q;
        sync_idx_d    = sync_idx_q;
        bit_cnt_d     = bit_cnt_q;
        eop_cnt_d     = eop_cnt_q;
        shift_d       = shift_q;
        inj_d         = inj_q;
        out_d         = '{line: LS_J, en: 1'b0, busy: out_q.busy, done: 1'b0};
        nrzi_bit_c    = 1'b0;
        nrzi_valid_c  = 1'b0;
        nrzi_load_k_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d.busy = 1'b0;
                if (start) begin
                    state_d    = ST_SYNC;
                    sync_idx_d = '0;
                    shift_d    = data_in;
                    inj_d      = inj_capture_c;
                    out_d.busy = 1'b1;
                end
            end

            ST_SYNC: begin
                out_d.line = sync_symbol(sync_idx_q, inj_q);
                out_d.en   = 1'b1;
                sync_idx_d = sync_idx_q + SYNC_IDX_W'(1);
                if (sync_idx_q == SYNC_IDX_W'(SYNC_LEN - 1)) begin
                    state_d       = ST_DATA;
                    bit_cnt_d     = '0;
                    nrzi_load_k_c = 1'b1;
                end
            end

            // Stuffed zero wins over data; once bits and stuffs are exhausted, first SE0.
            ST_DATA: begin
                out_d.en = 1'b1;
                if (stuff_req_c) begin
                    nrzi_valid_c = 1'b1;
                    nrzi_bit_c   = 1'b0;
                    out_d.line   = level_nxt_k_c ? LS_K : LS_J;
                end else if (bit_cnt_q != BIT_CNT_W'(DATA_W)) begin
                    nrzi_valid_c = 1'b1;
                    nrzi_bit_c   = shift_q[0];
                    out_d.line   = level_nxt_k_c ? LS_K : LS_J;
                    shift_d      = shift_q >> 1;
                    bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
                end else begin
                    out_d.line = LS_SE0;
                    state_d    = ST_EOP;
                    eop_cnt_d  = EOP_CNT_W'(1);
                end
            end

            ST_EOP: begin
                if (eop_cnt_q == EOP_CNT_W'(EOP_LEN)) begin
                    out_d.line = LS_J;
                    out_d.en   = 1'b0;
                    out_d.busy = 1'b0;
                    out_d.done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    out_d.line = LS_SE0;
                    out_d.en   = 1'b1;
                    eop_cnt_d  = eop_cnt_q + EOP_CNT_W'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                out_d.busy = 1'b0;
            end
        endcase
    end

endmodule
